// File: rtl/arbiter.sv
// ---------------------------------------------------------------------------
// arbiter
//   Round-robin arbiter in front of a shared resource. It grants at most one
//   of N requesters per cycle, and the grant is registered: req is sampled on
//   the rising clock edge and the grant appears in the following cycle.
//   The requester granted most recently drops to lowest priority for the next
//   arbitration. This gives starvation-free, fair access: any requester that
//   keeps req high is granted within N cycles.
//
// Parameters
//   N      number of requesters (N >= 2)
//
// Ports
//   clk    input   1   single clock, rising edge
//   rst_n  input   1   asynchronous active-low reset
//   req    input   N   request vector, bit i = requester i wants access
//   grant  output  N   registered one-hot (or all-zero) grant vector
// ---------------------------------------------------------------------------
module arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam int DW = $clog2(2 * N);

    // Lowest set bit of a 2N-wide vector. The scan runs downward, so the
    // lowest set bit is the last one written and is the one returned.
    function automatic logic [DW-1:0] lowest_set(input logic [2*N-1:0] v);
        logic [DW-1:0] idx;
        idx = {DW{1'b0}};
        for (int j = 2 * N - 1; j >= 0; j--) begin
            if (v[j]) begin
                idx = DW'(j);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    logic [PW-1:0]    ptr_r;        // index of the last granted requester
    logic [N-1:0]     grant_r;
    logic [2*N-1:0]   req_dbl_s;    // req duplicated so the search can wrap
    logic [2*N-1:0]   window_s;     // positions ptr+1 .. ptr+N of req_dbl_s
    logic [2*N-1:0]   cand_s;
    logic [DW-1:0]    dbl_idx_s;
    logic [PW-1:0]    win_idx_s;
    logic             win_vld_s;
    logic [N-1:0]     grant_nxt_s;

    assign req_dbl_s = {req, req};

    // Search window: bits strictly above ptr up to ptr+N. The last granted
    // index falls at ptr+N, which puts it last in the priority order.
    always_comb begin
        window_s = {(2*N){1'b0}};
        for (int j = 0; j < 2 * N; j++) begin
            if ((j > int'(ptr_r)) && (j <= int'(ptr_r) + N)) begin
                window_s[j] = 1'b1;
            end else begin
                window_s[j] = 1'b0;
            end
        end
    end

    assign cand_s = req_dbl_s & window_s;

    // Priority-encode the windowed candidates, then fold the doubled index back into 0..N-1.
    always_comb begin
        dbl_idx_s = lowest_set(cand_s);
        win_vld_s = |cand_s;
        if (int'(dbl_idx_s) >= N) begin
            win_idx_s = PW'(int'(dbl_idx_s) - N);
        end else begin
            win_idx_s = PW'(dbl_idx_s);
        end
    end

    // One-hot grant for the winner, or all-zero when nobody requests.
    always_comb begin
        grant_nxt_s = {N{1'b0}};
        if (win_vld_s) begin
            grant_nxt_s[win_idx_s] = 1'b1;
        end else begin
            grant_nxt_s = {N{1'b0}};
        end
    end

    // Grant and pointer registers. The pointer only moves when a grant is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_r <= {N{1'b0}};
            ptr_r   <= PW'(N - 1);
        end else begin
            grant_r <= grant_nxt_s;
            if (win_vld_s) begin
                ptr_r <= win_idx_s;
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign grant = grant_r;

endmodule

// File: tb/tb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_arbiter
//   Self-checking bench for the round-robin arbiter (N=4). Each time it drives
//   a req value, a reference model computes the expected grant and pushes it
//   onto a queue. The value is popped and compared one clock later, when the
//   registered grant appears.
// ---------------------------------------------------------------------------
module tb_arbiter;

    localparam int N = 4;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic [N-1:0] grant;

    int           vectors;
    int           miscompares;
    int           m_ptr;
    logic [N-1:0] exp_q[$];
    logic [N-1:0] e;

    arbiter #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive req and push the expected grant. The model walks the priority
    // order ptr+1 .. ptr+N (mod N) and takes the first active requester.
    task automatic set_req(input logic [N-1:0] v);
        logic [N-1:0] x;
        bit           found;
        x     = '0;
        found = 1'b0;
        req   = v;
        for (int k = 1; k <= N; k++) begin
            if (!found && v[(m_ptr + k) % N]) begin
                found = 1'b1;
                x[(m_ptr + k) % N] = 1'b1;
                m_ptr = (m_ptr + k) % N;
            end
        end
        exp_q.push_back(x);
    endtask

    task automatic drive_req(input logic [N-1:0] v);
        set_req(v);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = 4'b1111;
        m_ptr = N - 1;
        #2;
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_async: grant=%b expected=0000", grant);
        end
        #15;
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_held: grant=%b expected=0000", grant);
        end
        req = 4'b0000;
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_req(4'b0000);
        e = exp_q.pop_front();
        vectors++;
        if (grant !== 4'b0000 || grant !== e) begin
            miscompares++;
            $display("FAIL reset_release_idle: grant=%b expected=0000", grant);
        end
    endtask

    task automatic test_singles();
        logic [N-1:0] pat [5];
        pat = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            drive_req(pat[i]);
            e = exp_q.pop_front();
            vectors++;
            if (grant !== e || grant !== pat[i]) begin
                miscompares++;
                $display("FAIL single_%0d: req=%b grant=%b expected=%b", i, pat[i], grant, pat[i]);
            end
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] rq [7];
        logic [N-1:0] gx [7];
        rq = '{4'b0011, 4'b0111, 4'b1111, 4'b0001, 4'b1111, 4'b1011, 4'b1111};
        gx = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
        for (int i = 0; i < 7; i++) begin
            drive_req(rq[i]);
            e = exp_q.pop_front();
            vectors++;
            if (grant !== e) begin
                miscompares++;
                $display("FAIL rotation_model_%0d: req=%b grant=%b expected=%b", i, rq[i], grant, e);
            end
            vectors++;
            if (grant !== gx[i]) begin
                miscompares++;
                $display("FAIL rotation_table_%0d: req=%b grant=%b expected=%b", i, rq[i], grant, gx[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int cnt [N];
        for (int b = 0; b < N; b++) cnt[b] = 0;
        for (int i = 0; i < 8; i++) begin
            drive_req(4'b1111);
            e = exp_q.pop_front();
            vectors++;
            if (grant !== e) begin
                miscompares++;
                $display("FAIL saturation_%0d: grant=%b expected=%b", i, grant, e);
            end
            for (int b = 0; b < N; b++) if (grant[b] === 1'b1) cnt[b]++;
        end
        for (int b = 0; b < N; b++) begin
            vectors++;
            if (cnt[b] != 2) begin
                miscompares++;
                $display("FAIL saturation_count_bit%0d: grants=%0d expected=2", b, cnt[b]);
            end
        end
    endtask

    task automatic test_idle_and_async_reset();
        for (int i = 0; i < 2; i++) begin
            drive_req(4'b0000);
            e = exp_q.pop_front();
            vectors++;
            if (grant !== 4'b0000 || grant !== e) begin
                miscompares++;
                $display("FAIL idle_%0d: grant=%b expected=0000", i, grant);
            end
        end
        // Last grant was bit 0, so the search resumes at bit 1.
        drive_req(4'b1111);
        e = exp_q.pop_front();
        vectors++;
        if (grant !== 4'b0010 || grant !== e) begin
            miscompares++;
            $display("FAIL idle_resume: grant=%b expected=0010", grant);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (grant !== 4'b0000) begin
            miscompares++;
            $display("FAIL async_reset_midcycle: grant=%b expected=0000", grant);
        end
        m_ptr = N - 1;
        #2 rst_n = 1'b1;
        drive_req(4'b1111);
        e = exp_q.pop_front();
        vectors++;
        if (grant !== 4'b0001 || grant !== e) begin
            miscompares++;
            $display("FAIL after_async_reset: grant=%b expected=0001", grant);
        end
    endtask

    task automatic test_glitch();
        // req pulses between edges must not influence the sampled value.
        set_req(4'b0100);
        #2 req = 4'b1000;
        #2 req = 4'b0100;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (grant !== e) begin
            miscompares++;
            $display("FAIL glitch_req: grant=%b expected=%b", grant, e);
        end
        set_req(4'b0000);
        #2 req = 4'b1111;
        #2 req = 4'b0000;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        vectors++;
        if (grant !== e) begin
            miscompares++;
            $display("FAIL glitch_idle: grant=%b expected=%b", grant, e);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] prev;
        logic [N-1:0] v;
        for (int i = 0; i < 40; i++) begin
            v    = N'($urandom_range(0, 15));
            prev = v;
            drive_req(v);
            e = exp_q.pop_front();
            vectors++;
            if (grant !== e) begin
                miscompares++;
                $display("FAIL random_%0d: req=%b grant=%b expected=%b", i, v, grant, e);
            end
            vectors++;
            if (!$onehot0(grant) || ((grant & ~prev) !== 4'b0000)) begin
                miscompares++;
                $display("FAIL random_invariant_%0d: req=%b grant=%b expected onehot0 subset", i, prev, grant);
            end
        end
    endtask

    // Watchdog: the run must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ptr       = N - 1;
        test_reset();
        test_singles();
        test_rotation();
        test_saturation();
        test_idle_and_async_reset();
        test_glitch();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
